fft_frame_sequencer: RTL and testbench

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frames a 4-mic audio stream into FFT_LEN-beat AXI-Stream frames for a 4-lane complex FFT.
// Issues the FFT config word after reset and on request, but only between frames.
module fft_frame_sequencer #(
    parameter int unsigned FRAME_LEN   = 512,
    parameter logic [15:0] CFG_DEFAULT = 16'h0001
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic [63:0]                  audio_data_in,
    input  logic                         audio_valid_in,
    output logic [$clog2(FRAME_LEN)-1:0] next_index_out,
    output logic [127:0]                 fft_tdata_out,
    output logic                         fft_tvalid_out,
    output logic                         fft_tlast_out,
    input  logic                         fft_tready_in,
    output logic [15:0]                  cfg_tdata_out,
    output logic                         cfg_tvalid_out,
    input  logic                         cfg_tready_in,
    input  logic [15:0]                  cfg_word_in,
    input  logic                         cfg_req_in,
    output logic [15:0]                  frame_count_out,
    output logic [7:0]                   overrun_count_out,
    output logic                         busy_out
);

    localparam int unsigned IDX_W    = $clog2(FRAME_LEN);
    localparam int unsigned LANES    = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LANE_W   = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   index_nx;
    logic [127:0]       tdata_nx;
    logic               tvalid_nx;
    logic               tlast_nx;
    logic [15:0]        cfg_data_nx;
    logic               cfg_valid_nx;
    logic [15:0]        frame_cnt_nx;
    logic [7:0]         ovr_nx;
    logic               busy_nx;
    logic               pend, pend_nx;
    logic [15:0]        pend_word, pend_word_nx;
    logic               beat_done;
    logic               last_done;
    logic               boundary;
    logic               accept;
    logic               load_cfg;

    // Each 16-bit mic sample becomes the real part of one 32-bit complex lane.
    function automatic logic [127:0] pack_lanes(input logic [63:0] samples);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            d[LANE_W*i +: SAMPLE_W] = samples[SAMPLE_W*i +: SAMPLE_W];
        end
        return d;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= ST_CONFIG;
            next_index_out    <= '0;
            fft_tdata_out     <= '0;
            fft_tvalid_out    <= 1'b0;
            fft_tlast_out     <= 1'b0;
            cfg_tdata_out     <= CFG_DEFAULT;
            cfg_tvalid_out    <= 1'b1;
            frame_count_out   <= '0;
            overrun_count_out <= '0;
            busy_out          <= 1'b1;
            pend              <= 1'b0;
            pend_word         <= '0;
        end else begin
            state             <= state_nx;
            next_index_out    <= index_nx;
            fft_tdata_out     <= tdata_nx;
            fft_tvalid_out    <= tvalid_nx;
            fft_tlast_out     <= tlast_nx;
            cfg_tdata_out     <= cfg_data_nx;
            cfg_tvalid_out    <= cfg_valid_nx;
            frame_count_out   <= frame_cnt_nx;
            overrun_count_out <= ovr_nx;
            busy_out          <= busy_nx;
            pend              <= pend_nx;
            pend_word         <= pend_word_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        index_nx     = next_index_out;
        tdata_nx     = fft_tdata_out;
        tvalid_nx    = fft_tvalid_out;
        tlast_nx     = fft_tlast_out;
        cfg_data_nx  = cfg_tdata_out;
        frame_cnt_nx = frame_count_out;
        ovr_nx       = overrun_count_out;
        pend_nx      = pend;
        pend_word_nx = pend_word;
        boundary     = 1'b0;
        accept       = 1'b0;
        load_cfg     = 1'b0;
        beat_done    = fft_tvalid_out && fft_tready_in;
        last_done    = beat_done && fft_tlast_out;

        if (beat_done) begin
            tvalid_nx = 1'b0;
            tlast_nx  = 1'b0;
        end
        if (last_done) begin
            frame_cnt_nx = frame_count_out + 16'd1;
        end

        case (state)
            ST_CONFIG: begin
                if (cfg_tvalid_out && cfg_tready_in) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                boundary = 1'b1;
            end
            ST_STREAM: begin
                // Between frames: either the last beat is leaving now, or nothing of the next frame exists yet.
                if (last_done || (!fft_tvalid_out && (next_index_out == '0))) begin
                    boundary = 1'b1;
                end else if (audio_valid_in) begin
                    if (!fft_tvalid_out || fft_tready_in) begin
                        accept = 1'b1;
                    end else if (overrun_count_out != 8'hFF) begin
                        ovr_nx = overrun_count_out + 8'd1;
                    end
                end
            end
            default: begin
                state_nx = ST_CONFIG;
            end
        endcase

        if (boundary) begin
            if (pend) begin
                load_cfg = 1'b1;
                state_nx = ST_CONFIG;
            end else if (enable_in && audio_valid_in) begin
                accept   = 1'b1;
                state_nx = ST_STREAM;
            end else if (!enable_in) begin
                state_nx = ST_IDLE;
            end
        end

        if (accept) begin
            tdata_nx  = pack_lanes(audio_data_in);
            tvalid_nx = 1'b1;
            tlast_nx  = (next_index_out == LAST_IDX);
            index_nx  = next_index_out + IDX_W'(1);
        end

        // A request in the same cycle as a CONFIG entry stays pending for the next pass.
        if (load_cfg) begin
            cfg_data_nx = pend_word;
            pend_nx     = 1'b0;
        end
        if (cfg_req_in) begin
            pend_nx      = 1'b1;
            pend_word_nx = cfg_word_in;
        end

        cfg_valid_nx = (state_nx == ST_CONFIG);
        busy_nx      = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: frame-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fft_frame_sequencer;

    localparam int unsigned FRAME_LEN = 512;
    localparam int unsigned IW        = $clog2(FRAME_LEN);
    localparam logic [15:0] CFG_DEF   = 16'h0001;
    localparam int MODE_CFG    = 0;
    localparam int MODE_IDLE   = 1;
    localparam int MODE_STREAM = 2;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          enable      = 1'b0;
    logic [63:0]   audio_data  = '0;
    logic          audio_valid = 1'b0;
    logic          tready      = 1'b0;
    logic          cfg_tready  = 1'b0;
    logic [15:0]   cfg_word    = '0;
    logic          cfg_req     = 1'b0;

    logic [IW-1:0] next_index_out;
    logic [127:0]  fft_tdata_out;
    logic          fft_tvalid_out;
    logic          fft_tlast_out;
    logic [15:0]   cfg_tdata_out;
    logic          cfg_tvalid_out;
    logic [15:0]   frame_count_out;
    logic [7:0]    overrun_count_out;
    logic          busy_out;

    fft_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .CFG_DEFAULT(CFG_DEF)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .enable_in         (enable),
        .audio_data_in     (audio_data),
        .audio_valid_in    (audio_valid),
        .next_index_out    (next_index_out),
        .fft_tdata_out     (fft_tdata_out),
        .fft_tvalid_out    (fft_tvalid_out),
        .fft_tlast_out     (fft_tlast_out),
        .fft_tready_in     (tready),
        .cfg_tdata_out     (cfg_tdata_out),
        .cfg_tvalid_out    (cfg_tvalid_out),
        .cfg_tready_in     (cfg_tready),
        .cfg_word_in       (cfg_word),
        .cfg_req_in        (cfg_req),
        .frame_count_out   (frame_count_out),
        .overrun_count_out (overrun_count_out),
        .busy_out          (busy_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("Result: errors=%0d of %0d checks", errors, checks);
        end
        $finish;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            if (errors >= 40) finish_run();
        end
    endtask

    function automatic logic [127:0] pack(input logic [63:0] s);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[32*i +: 16] = s[16*i +: 16];
        return d;
    endfunction

    // Behavioural model: expected outputs plus bookkeeping about what was exchanged.
    int           m_mode = MODE_CFG;
    bit           m_in_frame = 1'b0;
    int           m_pos = 0;
    bit           m_tvalid = 1'b0;
    bit           m_tlast = 1'b0;
    logic [127:0] m_tdata = '0;
    logic [15:0]  m_frames = '0;
    logic [7:0]   m_ovr = '0;
    logic [15:0]  m_cfg_word = CFG_DEF;
    bit           m_pend = 1'b0;
    logic [15:0]  m_pend_word = '0;
    int           m_beats = 0;
    int           m_tlasts = 0;
    int           m_tlast_ord = -1;
    int           beat_in_frame = 0;
    int           m_cfg_beats = 0;
    logic [15:0]  m_cfg_hs_word = '0;

    task automatic take();
        m_tdata    = pack(audio_data);
        m_tvalid   = 1'b1;
        m_tlast    = (m_pos == int'(FRAME_LEN) - 1);
        m_pos      = (m_pos + 1) % int'(FRAME_LEN);
        m_in_frame = 1'b1;
    endtask

    task automatic model_step();
        bit hs;
        bit consumed;
        if (rst) begin
            m_mode = MODE_CFG; m_cfg_word = CFG_DEF; m_pend = 1'b0; m_pend_word = '0;
            m_in_frame = 1'b0; m_pos = 0; m_tvalid = 1'b0; m_tlast = 1'b0; m_tdata = '0;
            m_frames = '0; m_ovr = '0; beat_in_frame = 0;
            return;
        end
        hs = m_tvalid && tready;
        consumed = 1'b0;
        if (hs) begin
            m_beats++;
            beat_in_frame++;
            if (m_tlast) begin
                m_tlasts++;
                m_tlast_ord   = beat_in_frame - 1;
                beat_in_frame = 0;
                m_frames      = m_frames + 16'd1;
                m_in_frame    = 1'b0;
            end
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
        end
        if (m_mode == MODE_CFG) begin
            if (cfg_tready) begin
                m_cfg_beats++;
                m_cfg_hs_word = m_cfg_word;
                m_mode = MODE_IDLE;
            end
        end else if (!m_in_frame) begin
            if (m_pend) begin
                m_mode = MODE_CFG;
                m_cfg_word = m_pend_word;
                consumed = 1'b1;
            end else if (enable && audio_valid) begin
                take();
                m_mode = MODE_STREAM;
            end else if (!enable) begin
                m_mode = MODE_IDLE;
            end
        end else if (audio_valid) begin
            if (!m_tvalid) take();
            else if (m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
        end
        if (consumed) m_pend = 1'b0;
        if (cfg_req) begin
            m_pend = 1'b1;
            m_pend_word = cfg_word;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("tvalid", 128'(fft_tvalid_out), 128'(m_tvalid));
        if (m_tvalid) begin
            chk("tdata", fft_tdata_out, m_tdata);
            chk("tlast", 128'(fft_tlast_out), 128'(m_tlast));
        end
        chk("index", 128'(next_index_out), 128'(m_pos));
        chk("frame_count", 128'(frame_count_out), 128'(m_frames));
        chk("overrun", 128'(overrun_count_out), 128'(m_ovr));
        chk("cfg_tvalid", 128'(cfg_tvalid_out), 128'(m_mode == MODE_CFG));
        if (m_mode == MODE_CFG) chk("cfg_tdata", 128'(cfg_tdata_out), 128'(m_cfg_word));
        chk("busy", 128'(busy_out), 128'(m_mode != MODE_IDLE));
    end

    task automatic send(input int gap);
        audio_valid = 1'b1;
        audio_data  = {$urandom, $urandom};
        @(negedge clk);
        audio_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    logic [127:0] first_beat;
    int gaps;
    int cfg_seen;
    int beats_seen;

    initial begin
        rst = 1'b1; cfg_tready = 1'b1; enable = 1'b1; tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cfg_tdata", 128'(cfg_tdata_out), 128'(16'h0001));
        chk("rst_tvalid", 128'(fft_tvalid_out), 128'(1'b0));
        chk("rst_index", 128'(next_index_out), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_cfg_tvalid", 128'(cfg_tvalid_out), 128'(1'b1));
        chk("post_rst_busy", 128'(busy_out), 128'(1'b1));
        repeat (2) @(negedge clk);

        // Single frame at one strobe per 4 cycles.
        for (int i = 0; i < 512; i++) send(4);
        repeat (6) @(negedge clk);
        chk("f1_cfg_beats", 128'(m_cfg_beats), 128'(1));
        chk("f1_cfg_word", 128'(m_cfg_hs_word), 128'(16'h0001));
        chk("f1_beats", 128'(m_beats), 128'(512));
        chk("f1_tlasts", 128'(m_tlasts), 128'(1));
        chk("f1_tlast_ord", 128'(m_tlast_ord), 128'(511));
        chk("f1_frame_count", 128'(frame_count_out), 128'(16'd1));
        chk("f1_overrun", 128'(overrun_count_out), 128'(8'd0));

        // Backpressure across three strobes: first held, two dropped.
        for (int k = 0; k < 10; k++) begin
            tready = 1'b0;
            audio_valid = (k % 4 == 0);
            audio_data = {$urandom, $urandom};
            if (k == 0) first_beat = pack(audio_data);
            @(negedge clk);
        end
        audio_valid = 1'b0;
        chk("bp_overrun", 128'(overrun_count_out), 128'(8'd2));
        chk("bp_index", 128'(next_index_out), 128'(1));
        chk("bp_tvalid", 128'(fft_tvalid_out), 128'(1'b1));
        chk("bp_held_data", fft_tdata_out, first_beat);

        // Full rate: strobe in every handshake cycle.
        gaps = 0;
        for (int i = 0; i < 511; i++) begin
            tready = 1'b1; audio_valid = 1'b1; audio_data = {$urandom, $urandom};
            @(negedge clk);
            if (fft_tvalid_out !== 1'b1) gaps++;
        end
        audio_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("fr_gaps", 128'(gaps), 128'(0));
        chk("fr_frame_count", 128'(frame_count_out), 128'(16'd2));
        chk("fr_overrun", 128'(overrun_count_out), 128'(8'd2));

        // Config request mid-frame is held until the frame ends.
        cfg_tready = 1'b0;
        cfg_seen = 0;
        for (int i = 0; i < 512; i++) begin
            audio_valid = 1'b1; audio_data = {$urandom, $urandom};
            if (i == 100) begin cfg_req = 1'b1; cfg_word = 16'h0000; end
            @(negedge clk);
            audio_valid = 1'b0; cfg_req = 1'b0;
            if (cfg_tvalid_out) cfg_seen++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("cfg_mid_frame", 128'(cfg_seen), 128'(0));
        chk("cfg2_tvalid", 128'(cfg_tvalid_out), 128'(1'b1));
        chk("cfg2_tdata", 128'(cfg_tdata_out), 128'(16'h0000));
        chk("cfg2_frame_count", 128'(frame_count_out), 128'(16'd3));
        chk("cfg2_busy", 128'(busy_out), 128'(1'b1));
        send(2);
        chk("cfg_drop_overrun", 128'(overrun_count_out), 128'(8'd2));
        chk("cfg_drop_tvalid", 128'(fft_tvalid_out), 128'(1'b0));
        cfg_req = 1'b1; cfg_word = 16'h00AB;
        @(negedge clk);
        cfg_req = 1'b0;
        cfg_tready = 1'b1;
        @(negedge clk);
        cfg_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("cfg3_tvalid", 128'(cfg_tvalid_out), 128'(1'b1));
        chk("cfg3_tdata", 128'(cfg_tdata_out), 128'(16'h00AB));
        chk("cfg3_beats", 128'(m_cfg_beats), 128'(2));
        chk("cfg3_prev_word", 128'(m_cfg_hs_word), 128'(16'h0000));
        cfg_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("cfg3_done_busy", 128'(busy_out), 128'(1'b0));
        chk("cfg3_done_beats", 128'(m_cfg_beats), 128'(3));

        // Enable dropped mid-frame: frame completes, then idle.
        for (int i = 0; i < 512; i++) begin
            if (i == 300) enable = 1'b0;
            send(3);
        end
        repeat (4) @(negedge clk);
        chk("en_frame_count", 128'(frame_count_out), 128'(16'd4));
        chk("en_busy", 128'(busy_out), 128'(1'b0));
        chk("en_index", 128'(next_index_out), 128'(0));
        beats_seen = 0;
        for (int i = 0; i < 20; i++) begin
            audio_valid = 1'b1; audio_data = {$urandom, $urandom};
            @(negedge clk);
            audio_valid = 1'b0;
            if (fft_tvalid_out) beats_seen++;
            @(negedge clk);
        end
        chk("en_no_beats", 128'(beats_seen), 128'(0));
        enable = 1'b1;

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 200; i++) send(2);
        audio_valid = 1'b1; audio_data = {$urandom, $urandom};
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_tvalid", 128'(fft_tvalid_out), 128'(1'b0));
        chk("arst_tlast", 128'(fft_tlast_out), 128'(1'b0));
        chk("arst_tdata", fft_tdata_out, 128'(0));
        chk("arst_index", 128'(next_index_out), 128'(0));
        chk("arst_frames", 128'(frame_count_out), 128'(0));
        chk("arst_overrun", 128'(overrun_count_out), 128'(0));
        chk("arst_cfg_tdata", 128'(cfg_tdata_out), 128'(16'h0001));
        chk("arst_cfg_tvalid", 128'(cfg_tvalid_out), 128'(1'b1));
        @(negedge clk);
        audio_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(2);
        chk("arst_new_index", 128'(next_index_out), 128'(1));
        chk("arst_new_frames", 128'(frame_count_out), 128'(0));

        // Overrun counter saturation.
        for (int i = 0; i < 300; i++) begin
            tready = 1'b0; audio_valid = 1'b1; audio_data = {$urandom, $urandom};
            @(negedge clk);
        end
        audio_valid = 1'b0;
        chk("ovr_saturate", 128'(overrun_count_out), 128'(8'hFF));
        tready = 1'b1;
        @(negedge clk);

        // Randomized soak.
        for (int c = 0; c < 15000; c++) begin
            audio_valid = ($urandom % 3 == 0);
            audio_data  = {$urandom, $urandom};
            tready      = ($urandom % 4 != 0);
            enable      = ($urandom % 16 != 0);
            cfg_req     = ($urandom % 500 == 0);
            cfg_word    = 16'($urandom);
            cfg_tready  = ($urandom % 3 != 0);
            @(negedge clk);
        end
        audio_valid = 1'b0; cfg_req = 1'b0;
        repeat (3) @(negedge clk);
        finish_run();
    end

endmodule
